spi_ram_responder: RTL
======================

Name: spi_ram_responder

Overview:
- SPI target (mode 0) that emulates a 23LC-style serial SRAM. It is the responder end of the link driven by the SPI master core and memory controller.
- Decodes the READ (0x03) and WRITE (0x02) commands, each followed by a 16-bit address, and serves an internal byte array with sequential auto-increment.
- Used as a synthesizable stand-in for the external SPI RAM in simulation and FPGA bring-up.
- Oversamples the SPI pins on the system clock.

Parameters:
- ADDR_BITS, 8, width of internal array index; array holds 2^ADDR_BITS bytes; only the low ADDR_BITS bits of the 16-bit SPI address are used.
- SYNC_STAGES, 2, synchronizer flops on spi_clk, spi_mosi and spi_ce_n.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from master; idles low (mode 0).
- spi_mosi  in  1  master-out data, MSB first.
- spi_ce_n  in  1  chip enable, active low.
- spi_miso  out  1  responder-out data.
- spi_miso_oe  out  1  1 while in READ data phase; board tristates miso when 0.
- dbg_addr  in  ADDR_BITS  backdoor read address.
- dbg_data  out  8  combinational mem[dbg_addr].
- txn_active  out  1  1 from CE assert (synchronized) to CE deassert.
- cmd_error  out  1  one-cycle pulse when an unsupported command byte completes.

Behaviour:
- Reset:
  - spi_miso=0, spi_miso_oe=0, txn_active=0, cmd_error=0.
  - State IDLE, bit counter 0, address 0.
  - Array contents are not cleared.
- Timing constraint: the SPI clock high and low phases must each be at least 4 clk cycles. Faster SPI is unsupported and need not work.
- Synchronized pin samples feed edge detectors:
  - sclk_rise: sample mosi into the shift register and increment the bit count.
  - sclk_fall: shift the next miso bit out.
- CE deassert (synchronized spi_ce_n=1) has priority over everything:
  - Go to IDLE immediately.
  - spi_miso_oe=0, txn_active=0.
  - Any partial byte is discarded; no write occurs.
- CE assert while IDLE: go to CMD, bit count 0, txn_active=1.
- CMD: after 8 rising edges, compare the byte.
  - 0x03 or 0x02: go to ADDR_HI.
  - Any other value: pulse cmd_error and go to IGNORE.
- ADDR_HI and ADDR_LO each collect 8 bits into address[15:8] and [7:0].
  - After ADDR_LO, go to RD if cmd=0x03, else WR.
- RD:
  - On entry, load the shift-out register with mem[addr] and set oe=1.
  - The sclk_fall that follows the 24th rising edge drives bit7. Each subsequent fall drives the next bit.
  - After each 8th data rising edge: addr++, reload from mem[addr] (the new address), and drive bit7 on the next fall.
- WR: each complete 8-bit byte is written to mem[addr] in the cycle after its 8th rising edge, then addr++.
- Address wrap: addr increments modulo 2^ADDR_BITS, so 0xFF wraps to 0x00 with default parameters.
- IGNORE: all edges are ignored until CE deasserts; miso_oe stays 0.
- spi_miso holds its last value when oe=0. Its value is don't-care outside RD.
- CE deassert then reassert: starts a new transaction in CMD. No state carries over except the array.
- Reset mid-transaction: returns to IDLE, with the same values as power-on reset.
- A write cycle and a dbg_addr read of the same location in the same cycle return the old data.

Decomposition:
- Shared package spi_ram_pkg:
  - CMD_READ=8'h03, CMD_WRITE=8'h02.
  - State enum: IDLE, CMD, ADDR_HI, ADDR_LO, RD, WR, IGNORE.
- Sub-module spi_pin_sync: the SYNC_STAGES flop chain plus rise/fall detect for spi_clk, and synchronized mosi/ce_n. Instantiated once.

Test Plan:
- Write then read:
  - CE low, send 02 00 10 A5 5A, CE high → dbg at 0x10 reads A5, dbg at 0x11 reads 5A.
  - CE low, send 03 00 10, clock 16 bits → miso returns A5 then 5A.
- Wrap:
  - Write 02 00 FF 11 22 → mem[0xFF]=11, mem[0x00]=22.
  - Read 03 00 FF for 2 bytes → 11 22.
- Partial byte:
  - Send 02 00 20 then 5 bits of 1, CE high → mem[0x20] unchanged and txn_active falls.
- Bad command:
  - Send 9F → cmd_error pulses exactly once and miso_oe stays 0.
  - Next CE cycle with 03 00 10 reads A5 normally.
- Upper address bits:
  - Write 02 AB 30 77 → mem[0x30]=77 (upper bits ignored).
- Reset mid-read:
  - Assert rst during the second data byte of a read → spi_miso_oe=0 and txn_active=0 the next cycle.
  - After release and a new CE cycle, the read works.

Source files
------------

// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ---- spi_ram_pkg | shared command codes and FSM states for the SPI RAM responder | rev 1.0 ----
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        RD      = 3'd4,
        WR      = 3'd5,
        IGNORE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_ram_responder_if.sv
`default_nettype none
// ---- spi_ram_responder_if | SPI pin bundle between master and RAM responder | rev 1.0 ----
interface spi_ram_responder_if;

    logic spi_clk;
    logic spi_mosi;
    logic spi_ce_n;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_ce_n,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_mosi,
        input  spi_ce_n,
        output spi_miso,
        output spi_miso_oe
    );

endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ---- spi_pin_sync | synchronizers for SPI pins plus spi_clk edge detect | rev 1.0 ----
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_ce_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_sync,
    output logic ce_n_sync
);

    logic [SYNC_STAGES-1:0] r_clk_pipe;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;
    logic [SYNC_STAGES-1:0] r_ce_pipe;
    logic                   r_clk_prev;

    // Chip enable resets to the deasserted level so a reset never fakes a transaction start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_pipe  <= '0;
            r_mosi_pipe <= '0;
            r_ce_pipe   <= '1;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_pipe[0]  <= spi_clk;
            r_mosi_pipe[0] <= spi_mosi;
            r_ce_pipe[0]   <= spi_ce_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_pipe[i]  <= r_clk_pipe[i-1];
                r_mosi_pipe[i] <= r_mosi_pipe[i-1];
                r_ce_pipe[i]   <= r_ce_pipe[i-1];
            end
            r_clk_prev <= r_clk_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = r_clk_pipe[SYNC_STAGES-1] & ~r_clk_prev;
    assign sclk_fall = ~r_clk_pipe[SYNC_STAGES-1] & r_clk_prev;
    assign mosi_sync = r_mosi_pipe[SYNC_STAGES-1];
    assign ce_n_sync = r_ce_pipe[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_ram_responder.sv
`default_nettype none
// ---- spi_ram_responder | mode-0 SPI target emulating a 23LC-style serial SRAM | rev 1.0 ----
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_responder_if.slave   spi,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]           dbg_data,
    output logic                 txn_active,
    output logic                 cmd_error
);

    logic w_sclk_rise, w_sclk_fall, w_mosi, w_ce_n;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi.spi_clk),
        .spi_mosi  (spi.spi_mosi),
        .spi_ce_n  (spi.spi_ce_n),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .mosi_sync (w_mosi),
        .ce_n_sync (w_ce_n)
    );

    logic [7:0]           r_mem [2**ADDR_BITS];
    state_t               r_state,   state_n;
    logic [2:0]           r_bit_cnt, bit_cnt_n;
    logic [6:0]           r_sh,      sh_n;
    logic [15:0]          r_addr,    addr_n;
    logic                 r_is_read, is_read_n;
    logic [7:0]           r_tx,      tx_n;
    logic                 r_miso,    miso_n;
    logic                 r_oe,      oe_n;
    logic                 r_txn,     txn_n;
    logic                 r_cmd_err, cmd_err_n;
    logic                 r_wr_en,   wr_en_n;
    logic [ADDR_BITS-1:0] r_wr_addr, wr_addr_n;
    logic [7:0]           r_wr_data, wr_data_n;

    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic [15:0] w_addr_full;
    logic [15:0] w_addr_inc;

    assign w_byte      = {r_sh, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_addr_full = {r_addr[15:8], w_byte};

    // Auto-increment only touches the array index bits, so it wraps modulo the array size.
    always_comb begin
        w_addr_inc                  = r_addr;
        w_addr_inc[ADDR_BITS-1:0]   = r_addr[ADDR_BITS-1:0] + ADDR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_sh      <= 7'd0;
            r_addr    <= 16'd0;
            r_is_read <= 1'b0;
            r_tx      <= 8'd0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_txn     <= 1'b0;
            r_cmd_err <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
        end else begin
            r_state   <= state_n;
            r_bit_cnt <= bit_cnt_n;
            r_sh      <= sh_n;
            r_addr    <= addr_n;
            r_is_read <= is_read_n;
            r_tx      <= tx_n;
            r_miso    <= miso_n;
            r_oe      <= oe_n;
            r_txn     <= txn_n;
            r_cmd_err <= cmd_err_n;
            r_wr_en   <= wr_en_n;
            r_wr_addr <= wr_addr_n;
            r_wr_data <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = r_state;
        bit_cnt_n = r_bit_cnt;
        sh_n      = r_sh;
        addr_n    = r_addr;
        is_read_n = r_is_read;
        tx_n      = r_tx;
        miso_n    = r_miso;
        oe_n      = r_oe;
        txn_n     = r_txn;
        cmd_err_n = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = r_wr_addr;
        wr_data_n = r_wr_data;

        if (w_ce_n) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            oe_n      = 1'b0;
            txn_n     = 1'b0;
        end else begin
            if (w_sclk_rise && r_state != IDLE && r_state != IGNORE) begin
                sh_n      = w_byte[6:0];
                bit_cnt_n = r_bit_cnt + 3'd1;
            end
            case (r_state)
                IDLE: begin
                    state_n   = CMD;
                    bit_cnt_n = 3'd0;
                    txn_n     = 1'b1;
                end
                CMD: begin
                    if (w_byte_done) begin
                        if (w_byte == CMD_READ || w_byte == CMD_WRITE) begin
                            state_n   = ADDR_HI;
                            is_read_n = (w_byte == CMD_READ);
                        end else begin
                            state_n   = IGNORE;
                            cmd_err_n = 1'b1;
                        end
                    end
                end
                ADDR_HI: begin
                    if (w_byte_done) begin
                        addr_n[15:8] = w_byte;
                        state_n      = ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (w_byte_done) begin
                        addr_n = w_addr_full;
                        if (r_is_read) begin
                            state_n = RD;
                            tx_n    = r_mem[w_addr_full[ADDR_BITS-1:0]];
                            oe_n    = 1'b1;
                        end else begin
                            state_n = WR;
                        end
                    end
                end
                RD: begin
                    if (w_sclk_fall) begin
                        miso_n = r_tx[7];
                        tx_n   = {r_tx[6:0], 1'b0};
                    end
                    if (w_byte_done) begin
                        addr_n = w_addr_inc;
                        tx_n   = r_mem[w_addr_inc[ADDR_BITS-1:0]];
                    end
                end
                WR: begin
                    if (w_byte_done) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = r_addr[ADDR_BITS-1:0];
                        wr_data_n = w_byte;
                        addr_n    = w_addr_inc;
                    end
                end
                IGNORE: begin
                    state_n = IGNORE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Array has no reset so its contents survive rst, like the real part.
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    assign dbg_data        = r_mem[dbg_addr];
    assign spi.spi_miso    = r_miso;
    assign spi.spi_miso_oe = r_oe;
    assign txn_active      = r_txn;
    assign cmd_error       = r_cmd_err;

endmodule
`default_nettype wire
